femto_rst_seq: RTL and testbench
================================

FEMTO_RST_SEQ -- requirements
Module: femto_rst_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1024, cycles held after lock before peripheral reset release (>=1).
REQ-002 SHALL have parameter CORE_DELAY, default 16, cycles between peripheral and core reset release (>=1).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 65536, consecutive low cycles of btn_n that count as a press (>=1).
REQ-004 SHALL have port clk, input, 1, system clock (the buffered PLL output).
REQ-005 SHALL have port resetn, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port pll_locked, input, 1, PLL lock status, asynchronous to clk (tie 1 if unavailable).
REQ-007 SHALL have port btn_n, input, 1, external reset button, active-low, asynchronous, bouncing.
REQ-008 SHALL have port periph_resetn, output, 1, active-low reset to peripherals.
REQ-009 SHALL have port core_resetn, output, 1, active-low reset to the FemtoRV core.
REQ-010 SHALL have port ready, output, 1, high only when the sequence has completed (state RUN).

Function
REQ-011 SHALL pass pll_locked through a 2-flop synchronizer (locked_s) and btn_n through a 2-flop synchronizer (btn_s), each adding 2 cycles of latency.
REQ-012 SHALL count consecutive cycles with btn_s==0 in btn_cnt, saturating at DEBOUNCE_CYCLES and cleared on any cycle with btn_s==1; btn_held = (btn_cnt==DEBOUNCE_CYCLES).
REQ-013 SHALL implement FSM states WAIT_LOCK, HOLD, PERIPH, RUN with a shared counter cnt, sized $clog2(max(HOLD_CYCLES,CORE_DELAY)+1).
REQ-014 WAIT_LOCK: on locked_s==1 and !btn_held -> HOLD, with cnt=0.
REQ-015 HOLD: increment cnt; when cnt==HOLD_CYCLES-1 -> PERIPH, with cnt=0.
REQ-016 PERIPH: increment cnt; when cnt==CORE_DELAY-1 -> RUN.
REQ-017 RUN: remain until an abort.
REQ-018 Abort: in any state, locked_s==0 or btn_held -> WAIT_LOCK with cnt=0; abort has priority over every counter terminal condition in the same cycle.
REQ-019 Outputs SHALL be registered and updated on the same edge as the state: periph_resetn=1 iff state is PERIPH or RUN; core_resetn=ready=1 iff state is RUN.
REQ-020 Timing: with edge 1 the first edge sampling pll_locked high, HOLD SHALL be entered at edge 3, periph_resetn SHALL rise at edge 3+HOLD_CYCLES, and core_resetn SHALL rise at edge 3+HOLD_CYCLES+CORE_DELAY.
REQ-021 A pll_locked drop sampled at edge 1 SHALL drive all outputs low at edge 3.
REQ-022 A btn_n press sampled at edge 1 and held SHALL drive all outputs low at edge 3+DEBOUNCE_CYCLES; presses of DEBOUNCE_CYCLES-1 cycles or fewer SHALL have no effect.
REQ-023 While btn_held stays true the FSM SHALL remain in WAIT_LOCK; after release the sequence SHALL restart per REQ-020.
REQ-024 cnt SHALL never wrap; the terminal comparisons are exact.

Reset
REQ-025 resetn low SHALL asynchronously set state=WAIT_LOCK, cnt=0, btn_cnt=0, all output flops low, locked_s synchronizer flops to 0, and btn_s synchronizer flops to 1.
REQ-026 resetn deassertion SHALL pass through an internal 2-flop reset synchronizer (async assert, sync release); the FSM SHALL not leave WAIT_LOCK earlier than 2 edges after resetn rises.
REQ-027 resetn asserted mid-sequence (any state) SHALL drop all outputs immediately, without waiting for a clock edge.

Structure
REQ-028 Package femto_rst_pkg SHALL hold the state encoding typedef and the default values of HOLD_CYCLES, CORE_DELAY and DEBOUNCE_CYCLES.
REQ-029 Sub-module femto_sync2 (2-flop synchronizer, parameterized reset value) SHALL be instantiated for pll_locked, btn_n, and the reset release.

Verification (HOLD_CYCLES=8, CORE_DELAY=4, DEBOUNCE_CYCLES=4)
REQ-030 pll_locked=1 from edge 1 after reset release -> periph_resetn rises at edge 11, core_resetn and ready rise at edge 15, nothing toggles earlier.
REQ-031 pll_locked dropped for 1 cycle while in RUN -> all outputs low 2 edges after sampling, then the full sequence repeats (periph after +11, core after +15 from relock).
REQ-032 btn_n low 3 cycles in RUN -> outputs stay high; btn_n low 4+ cycles -> outputs low at edge 7 after press, held low until release, then restart.
REQ-033 pll_locked drop on the same edge cnt reaches HOLD_CYCLES-1 -> FSM goes to WAIT_LOCK, periph_resetn never rises.
REQ-034 resetn pulsed low asynchronously mid-PERIPH -> periph_resetn falls with no clock edge; after release the sequence restarts from WAIT_LOCK.

Source files
------------

// File: rtl/femto_rst_pkg.sv
// femto_rst_pkg: shared definitions for the FemtoRV reset sequencer.
//   state_t              - FSM state encoding (WAIT_LOCK, HOLD, PERIPH, RUN)
//   DEF_*                - default timing parameters of femto_rst_seq
//   max_u()              - elaboration-time helper for counter sizing
//   periph_on()/core_on() - output decode of a state
package femto_rst_pkg;

  // Plain vector encoding keeps the states easy to probe from legacy benches.
  typedef logic [1:0] state_t;

  localparam state_t WAIT_LOCK = 2'd0;
  localparam state_t HOLD      = 2'd1;
  localparam state_t PERIPH    = 2'd2;
  localparam state_t RUN       = 2'd3;

  localparam int unsigned DEF_HOLD_CYCLES     = 1024;
  localparam int unsigned DEF_CORE_DELAY      = 16;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 65536;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Peripherals come out of reset one stage before the core.
  function automatic logic periph_on(input state_t st);
    return (st == PERIPH) || (st == RUN);
  endfunction

  function automatic logic core_on(input state_t st);
    return (st == RUN);
  endfunction

endpackage

// File: rtl/femto_rst_seq_if.sv
// femto_rst_seq_if: board-side signal bundle of the reset sequencer.
//   pll_locked     - PLL lock status, asynchronous to clk
//   btn_n          - external reset button, active-low, bouncing
//   periph_resetn  - active-low reset to peripherals
//   core_resetn    - active-low reset to the core
//   ready          - high once the sequence has completed
// Modports: master drives the inputs and observes the resets (board/bench),
//           slave is the sequencer itself.
interface femto_rst_seq_if;

  logic pll_locked;
  logic btn_n;
  logic periph_resetn;
  logic core_resetn;
  logic ready;

  modport master (
    output pll_locked,
    output btn_n,
    input  periph_resetn,
    input  core_resetn,
    input  ready
  );

  modport slave (
    input  pll_locked,
    input  btn_n,
    output periph_resetn,
    output core_resetn,
    output ready
  );

endinterface

// File: rtl/femto_sync2.sv
// femto_sync2: two-flop synchronizer with asynchronous reset.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, loads RESET_VAL into both flops
//   d     - asynchronous input
//   q     - synchronized output, two clk edges of latency
// Also used as a reset synchronizer by tying d high: assertion is immediate,
// release follows two edges later.
module femto_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/femto_rst_seq.sv
// femto_rst_seq: power-on / button reset sequencer for the FemtoRV SoC.
//   clk     - system clock (buffered PLL output)
//   resetn  - asynchronous active-low reset, released through a synchronizer
//   bus     - femto_rst_seq_if.slave:
//               pll_locked, btn_n in; periph_resetn, core_resetn, ready out
// Sequence: wait for a synchronized PLL lock with no held button, hold for
// HOLD_CYCLES, release peripherals, wait CORE_DELAY, release the core.
// Loss of lock or a debounced button press restarts from WAIT_LOCK.
module femto_rst_seq
  import femto_rst_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned CORE_DELAY      = DEF_CORE_DELAY,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input logic            clk,
  input logic            resetn,
  femto_rst_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, CORE_DELAY) + 1);
  localparam int unsigned BTN_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY - 1);
  localparam logic [BTN_W-1:0] BTN_ONE   = BTN_W'(1);
  localparam logic [BTN_W-1:0] BTN_MAX   = BTN_W'(DEBOUNCE_CYCLES);

  // ---------------------------------------------------------------------------
  // Synchronizers
  // ---------------------------------------------------------------------------
  logic rst_sync_n;
  logic locked_s;
  logic btn_s;

  // Async assert follows resetn at once; release is two edges later.
  femto_sync2 #(
    .RESET_VAL(1'b0)
  ) u_rst_sync (
    .clk  (clk),
    .rst_n(resetn),
    .d    (1'b1),
    .q    (rst_sync_n)
  );

  // Lock reads as lost while in reset.
  femto_sync2 #(
    .RESET_VAL(1'b0)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_sync_n),
    .d    (bus.pll_locked),
    .q    (locked_s)
  );

  // Button reads as released while in reset.
  femto_sync2 #(
    .RESET_VAL(1'b1)
  ) u_btn_sync (
    .clk  (clk),
    .rst_n(rst_sync_n),
    .d    (bus.btn_n),
    .q    (btn_s)
  );

  // ---------------------------------------------------------------------------
  // Button debounce: a press counts only after DEBOUNCE_CYCLES consecutive
  // low samples; any high sample clears the run.
  // ---------------------------------------------------------------------------
  logic [BTN_W-1:0] btn_cnt_q, btn_cnt_d;
  logic             btn_held;

  assign btn_held = (btn_cnt_q == BTN_MAX);

  always_comb begin
    btn_cnt_d = btn_cnt_q;
    if (btn_s) begin
      btn_cnt_d = '0;
    end else if (!btn_held) begin
      btn_cnt_d = btn_cnt_q + BTN_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort;
  logic             periph_q, core_q;

  assign abort = !locked_s || btn_held;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // Abort wins over any terminal count reached on the same edge.
    if (abort) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = PERIPH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PERIPH: begin
          if (cnt_q == CORE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      btn_cnt_q <= '0;
      periph_q  <= 1'b0;
      core_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_cnt_q <= btn_cnt_d;
      periph_q  <= periph_on(state_d);
      core_q    <= core_on(state_d);
    end
  end

  assign bus.periph_resetn = periph_q;
  assign bus.core_resetn   = core_q;
  assign bus.ready         = core_q;

endmodule

// File: tb/tb_femto_rst_seq.sv
// tb_femto_rst_seq: self-checking bench for femto_rst_seq with short timing
// parameters. The reference model counts consecutive "healthy" edges: an edge
// is unhealthy when the lock sampled two edges earlier was low, or when the
// DEBOUNCE_CYCLES button samples before that were all low. Peripherals are out
// of reset after HOLD+1 healthy edges, the core after HOLD+CORE+1.
module tb_femto_rst_seq;

  localparam int unsigned H  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned HN = 16;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  femto_rst_seq_if bus ();

  femto_rst_seq #(
    .HOLD_CYCLES    (H),
    .CORE_DELAY     (D),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: raw input history (index 0 = most recent edge sample)
  // and the count of consecutive healthy edges.
  logic        hist_lock [HN];
  logic        hist_btn  [HN];
  int unsigned healthy;

  function automatic logic model_unhealthy();
    logic pressed;
    pressed = 1'b1;
    for (int k = 2; k < 2 + DB; k++) begin
      if (hist_btn[k]) pressed = 1'b0;
    end
    return !hist_lock[1] || pressed;
  endfunction

  function automatic logic [2:0] model_out();
    logic p, c;
    p = (healthy >= H + 1);
    c = (healthy >= H + D + 1);
    return {p, c, c};
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      healthy <= 0;
      for (int i = 0; i < HN; i++) begin
        hist_lock[i] <= 1'b0;
        hist_btn[i]  <= 1'b1;
      end
    end else begin
      healthy <= model_unhealthy() ? 0 : ((healthy < 1000) ? healthy + 1 : healthy);
      hist_lock[0] <= bus.pll_locked;
      hist_btn[0]  <= bus.btn_n;
      for (int i = 1; i < HN; i++) begin
        hist_lock[i] <= hist_lock[i-1];
        hist_btn[i]  <= hist_btn[i-1];
      end
    end
  end

  logic [2:0] dut_out;
  assign dut_out = {bus.periph_resetn, bus.core_resetn, bus.ready};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.pll_locked = 1'b0;
    bus.btn_n      = 1'b1;
    #3 resetn = 1'b0;
    #1;
    checks++;
    if (dut_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_assert got %b want 000", dut_out);
    end
    repeat (3) step();
    resetn = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if (dut_out !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got %b want 000", n, dut_out);
      end
    end
  endtask

  // Lock raised so that the next edge is edge 1.
  task automatic test_sequence();
    logic [2:0] exp;
    bus.pll_locked = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      exp = {n >= 11, n >= 15, n >= 15};
      checks++;
      if (dut_out !== exp) begin
        errors++;
        $display("FAIL sequence edge %0d got %b want %b", n, dut_out, exp);
      end
    end
  endtask

  // One-cycle lock drop from RUN, sampled at edge 1, relock sampled at edge 2.
  task automatic test_lock_drop();
    logic [2:0] exp;
    bus.pll_locked = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      step();
      if (n == 1) bus.pll_locked = 1'b1;
      exp = {(n < 3) || (n >= 12), (n < 3) || (n >= 16), (n < 3) || (n >= 16)};
      checks++;
      if (dut_out !== exp) begin
        errors++;
        $display("FAIL lock_drop edge %0d got %b want %b", n, dut_out, exp);
      end
    end
  endtask

  task automatic test_button();
    int unsigned lens[7];
    lens[0] = DB - 1;
    lens[1] = DB;
    lens[2] = DB + 2;
    for (int i = 3; i < 7; i++) lens[i] = $urandom_range(1, 2 * DB);
    for (int i = 0; i < 7; i++) begin
      bus.btn_n = 1'b0;
      for (int n = 1; n <= 30; n++) begin
        step();
        if (n == int'(lens[i])) bus.btn_n = 1'b1;
        checks++;
        if (dut_out !== model_out()) begin
          errors++;
          $display("FAIL button len %0d edge %0d got %b want %b",
                   lens[i], n, dut_out, model_out());
        end
      end
    end
  endtask

  // Lock lost exactly when the hold count reaches its last value.
  task automatic test_hold_abort();
    bus.pll_locked = 1'b0;
    repeat (4) step();
    bus.pll_locked = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (n == 7)  bus.pll_locked = 1'b0;
      if (n == 12) bus.pll_locked = 1'b1;
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL hold_abort edge %0d got %b want %b", n, dut_out, model_out());
      end
      if (n <= 22) begin
        checks++;
        if (bus.periph_resetn !== 1'b0) begin
          errors++;
          $display("FAIL hold_abort_periph edge %0d got %b want 0", n, bus.periph_resetn);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bus.pll_locked = 1'b0;
    repeat (4) step();
    bus.pll_locked = 1'b1;
    repeat (12) step();
    checks++;
    if (dut_out !== 3'b100) begin
      errors++;
      $display("FAIL async_pre got %b want 100", dut_out);
    end
    #2 resetn = 1'b0;
    bus.pll_locked = 1'b0;
    #1;
    checks++;
    if (dut_out !== 3'b000) begin
      errors++;
      $display("FAIL async_drop got %b want 000", dut_out);
    end
    repeat (3) step();
    resetn = 1'b1;
    repeat (4) step();
    bus.pll_locked = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      checks++;
      if (dut_out !== model_out() || bus.periph_resetn !== (n >= 11)) begin
        errors++;
        $display("FAIL async_restart edge %0d got %b want %b", n, dut_out, model_out());
      end
    end
  endtask

  task automatic test_random();
    int unsigned press_left = 0;
    int unsigned drop_left  = 0;
    for (int n = 0; n < 600; n++) begin
      if (press_left == 0 && $urandom_range(0, 99) < 4) press_left = $urandom_range(1, 2 * DB);
      if (drop_left == 0 && $urandom_range(0, 99) < 2) drop_left = $urandom_range(1, 3);
      bus.btn_n      = (press_left == 0);
      bus.pll_locked = (drop_left == 0);
      if (press_left != 0) press_left--;
      if (drop_left != 0) drop_left--;
      step();
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL random cycle %0d got %b want %b", n, dut_out, model_out());
      end
    end
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    bus.btn_n      = 1'b1;
    test_reset();
    test_sequence();
    test_lock_drop();
    test_button();
    test_hold_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
